// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit layout and endpoint types
package noc_pkg;

  localparam int COORD_W = 2;
  localparam int DATA_W  = 32;
  localparam int FLIT_W  = 40;

  typedef struct packed {
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [COORD_W-1:0] src_x;
    logic [COORD_W-1:0] src_y;
    logic [DATA_W-1:0]  data;
  } flit_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/noc_ep_fifo.sv
// rtl/noc_ep_fifo.sv - synchronous FIFO holding received flits for the core
module noc_ep_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so plain pointer overflow is the modulo wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_endpoint.sv
// rtl/noc_endpoint.sv - mesh NoC local-port endpoint; NOC_EP_STATS_EN adds traffic counters
module noc_endpoint
  import noc_pkg::*;
#(
  parameter int XCOORD = 0,
  parameter int YCOORD = 0,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COORD_W-1:0]  req_dst_x,
  input  logic [COORD_W-1:0]  req_dst_y,
  input  logic [DATA_W-1:0]   req_data,
  output logic                net_out_valid,
  input  logic                net_out_ready,
  output logic [FLIT_W-1:0]   net_out_flit,
  input  logic                net_in_valid,
  output logic                net_in_ready,
  input  logic [FLIT_W-1:0]   net_in_flit,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [COORD_W-1:0]  rsp_src_x,
  output logic [COORD_W-1:0]  rsp_src_y,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                misroute
`ifdef NOC_EP_STATS_EN
  ,
  output logic [15:0]         tx_count,
  output logic [15:0]         rx_count,
  output logic [15:0]         drop_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_t state, state_nx;
  flit_t     tx_flit, tx_flit_nx;
  flit_t     req_flit;

  assign req_flit = '{dst_x: req_dst_x, dst_y: req_dst_y,
                      src_x: COORD_W'(XCOORD), src_y: COORD_W'(YCOORD),
                      data:  req_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      tx_flit <= '0;
    end else begin
      state   <= state_nx;
      tx_flit <= tx_flit_nx;
    end
  end

  // In SEND a new request is only taken alongside the router's accept
  always_comb begin
    state_nx      = state;
    tx_flit_nx    = tx_flit;
    req_ready     = 1'b1;
    net_out_valid = 1'b0;
    case (state)
      TX_IDLE: begin
        if (req_valid) begin
          tx_flit_nx = req_flit;
          state_nx   = TX_SEND;
        end
      end
      TX_SEND: begin
        net_out_valid = 1'b1;
        req_ready     = net_out_ready;
        if (net_out_ready) begin
          if (req_valid) tx_flit_nx = req_flit;
          else           state_nx   = TX_IDLE;
        end
      end
      default: state_nx = TX_IDLE;
    endcase
  end

  assign net_out_flit = tx_flit;

  flit_t           rx_flit, head;
  logic            dst_match, rx_xfer, fifo_push, fifo_pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign rx_flit      = flit_t'(net_in_flit);
  assign net_in_ready = (fifo_count != CW'(DEPTH));
  assign rx_xfer      = net_in_valid && net_in_ready;
  assign dst_match    = (rx_flit.dst_x == COORD_W'(XCOORD)) &&
                        (rx_flit.dst_y == COORD_W'(YCOORD));
  assign fifo_push    = rx_xfer && dst_match && !fifo_full;
  assign misroute     = rx_xfer && !dst_match;
  assign fifo_pop     = rsp_valid && rsp_ready;

  noc_ep_fifo #(.DEPTH(DEPTH), .T(flit_t)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (rx_flit),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_src_x = head.src_x;
  assign rsp_src_y = head.src_y;
  assign rsp_data  = head.data;

`ifdef NOC_EP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_count   <= '0;
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (net_out_valid && net_out_ready) tx_count   <= sat_inc(tx_count);
      if (fifo_push)                      rx_count   <= sat_inc(rx_count);
      if (misroute)                       drop_count <= sat_inc(drop_count);
    end
  end
`endif

endmodule

// File: doc/noc_endpoint.md
# noc_endpoint

Local-port network interface for one node of the 4x4 mesh NoC. Sits between a core and its router's local port. Packs core send requests into single-flit packets and injects them toward the router. Accepts flits the router ejects, checks the destination, buffers them, and presents them to the core.

## Interface
Parameters:
- XCOORD, 0, this node's column (0..3); inserted as source X, checked against destination X
- YCOORD, 0, this node's row (0..3); inserted as source Y, checked against destination Y
- DEPTH, 4, RX FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  control clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  core has a message to send
- req_ready  out  1  endpoint accepts request this cycle
- req_dst_x, req_dst_y  in  2 each  destination coordinates
- req_data  in  32  payload
- net_out_valid  out  1  flit toward router local input valid
- net_out_ready  in  1  router accepts flit
- net_out_flit  out  40  outgoing flit
- net_in_valid  in  1  router local output presents flit
- net_in_ready  out  1  endpoint can accept flit
- net_in_flit  in  40  incoming flit
- rsp_valid  out  1  received message available
- rsp_ready  in  1  core consumes message
- rsp_src_x, rsp_src_y  out  2 each  sender coordinates
- rsp_data  out  32  payload
- misroute  out  1  one-cycle pulse on dropped flit

## Operation
- Flit layout: [39:38] dst_x, [37:36] dst_y, [35:34] src_x, [33:32] src_y, [31:0] data.
- TX FSM, states IDLE and SEND:
  - IDLE: req_ready=1 and net_out_valid=0. On req_valid, latch the flit with src = XCOORD/YCOORD and go to SEND.
  - SEND: net_out_valid=1 and the flit is held stable. req_ready = net_out_ready.
  - On net_out_ready with req_valid, load the next flit and stay in SEND (back-to-back, one flit per cycle).
  - On net_out_ready without req_valid, go to IDLE.
- Self-addressed requests are sent to the network like any other; no internal loopback.
- RX: net_in_ready = !full, derived from the registered count only. A flit transfers when net_in_valid && net_in_ready.
  - If dst matches XCOORD/YCOORD: push to FIFO.
  - Otherwise: drop, no push, and misroute=1 for that cycle.
- Core side: rsp_valid = !empty, outputs show the FIFO head, and rsp_valid && rsp_ready pops.
- Full with a simultaneous pop: net_in_ready stays 0 that cycle; no push. Empty: push only, and pop is ignored.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Timing
- Reset values: net_out_valid=0, net_out_flit=0, rsp_valid=0, misroute=0, FIFO empty, net_in_ready=1, TX state IDLE, req_ready=1.
- TX latency: request accepted at edge N → net_out_valid=1 after edge N. Valid never drops before ready.
- RX latency: flit accepted at edge N → rsp_valid=1 after edge N.
- net_in_ready: drops the cycle after the push that fills the FIFO; rises the cycle after the first pop from full.
- Reset asserted mid-operation: an in-flight TX flit is discarded and the FIFO contents are lost. There is no partial handshake on the following edge.

## Configuration
- NOC_EP_STATS_EN defined: adds outputs tx_count, rx_count and drop_count (16 bits each). They reset to 0, increment on each TX transfer / FIFO push / misroute, and saturate at 0xFFFF.
- Without the macro: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package noc_pkg:
  - COORD_W=2, DATA_W=32, FLIT_W=40
  - packed struct flit_t {dst_x, dst_y, src_x, src_y, data}
  - flit_t is shared with the routers.
- Sub-module noc_ep_fifo: synchronous FIFO parameterised on DEPTH and element type, with full/empty/count outputs.
- The TX FSM and address check stay in noc_endpoint.

## Test plan
- Node (1,2), single send: req dst=(3,0), data=0xDEADBEEF → net_out_flit=0xC_6_DEADBEEF (dst 3,0, src 1,2) one cycle later, held until net_out_ready.
- Back-to-back TX: 4 requests with net_out_ready=1 → 4 flits on 4 consecutive cycles; req_ready stays 1.
- TX backpressure: net_out_ready=0 for 5 cycles → flit stable, req_ready=0, no request lost.
- RX fill: DEPTH=4, rsp_ready=0, 5 valid flits to (1,2) → first 4 stored, net_in_ready=0 after the 4th; draining returns data in order.
- Misroute: flit dst=(0,0) at node (1,2) → misroute pulses once, rsp_valid stays 0; with NOC_EP_STATS_EN, drop_count=1.
- Reset mid-SEND and with a 2-entry FIFO: rst_n low for one cycle → net_out_valid=0, rsp_valid=0, net_in_ready=1 after the edge.
